// File: rtl/divisor_sequencial_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package divisor_sequencial_pkg;

    localparam int N_BITS = 8;
    localparam logic [7:0] DIV0_QUOC = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divisor_sequencial_subtrator8bits.sv
// 8-bit ripple-borrow subtractor (S = A - B - Bin) built from full-subtractor cells.
module subtratorCompleto (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic s,
    output logic bout
);

    assign s    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

module subtrator8bits (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       bin,
    output logic [7:0] s,
    output logic       bout
);

    logic [8:0] borrow;

    assign borrow[0] = bin;
    assign bout      = borrow[8];

    for (genvar i = 0; i < 8; i++) begin : g_cell
        subtratorCompleto u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .bin  (borrow[i]),
            .s    (s[i]),
            .bout (borrow[i+1])
        );
    end

endmodule

// File: rtl/divisor_sequencial.sv
// Sequential 8-bit unsigned restoring divider: one quotient bit per clock through
// a shared ripple subtractor, with start/busy/done handshake and divide-by-zero flag.
module divisor_sequencial #(
    parameter int N_BITS = divisor_sequencial_pkg::N_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_BITS-1:0] dividendo,
    input  logic [N_BITS-1:0] divisor,
    output logic [N_BITS-1:0] quociente,
    output logic [N_BITS-1:0] resto,
    output logic              busy,
    output logic              done,
    output logic              div_zero
);

    import divisor_sequencial_pkg::*;

    localparam int CW = $clog2(N_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(N_BITS - 1);

    state_t state, state_nxt;

    logic [N_BITS-1:0] d_reg, q_reg, r_reg;
    logic [CW-1:0]     cnt;

    logic [N_BITS-1:0] rs, diff, r_nxt, q_nxt;
    logic              bout, qbit;

    // Shift the next dividend bit into the partial remainder, then try to subtract D.
    assign rs = {r_reg[N_BITS-2:0], q_reg[N_BITS-1]};

    subtrator8bits u_sub (
        .a    (rs),
        .b    (d_reg),
        .bin  (1'b0),
        .s    (diff),
        .bout (bout)
    );

    // The bit shifted out of R is a ninth remainder bit; when set, Rs >= D even
    // though the 8-bit subtraction borrows, and the wrapped difference is exact.
    assign qbit  = r_reg[N_BITS-1] | ~bout;
    assign r_nxt = qbit ? diff : rs;
    assign q_nxt = {q_reg[N_BITS-2:0], qbit};

    assign busy = (state == ST_CALC);
    assign done = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start) state_nxt = (divisor == '0) ? ST_DONE : ST_CALC;
            ST_CALC: if (cnt == CNT_LAST) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_reg     <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            cnt       <= '0;
            quociente <= '0;
            resto     <= '0;
            div_zero  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quociente <= DIV0_QUOC;
                            resto     <= dividendo;
                            div_zero  <= 1'b1;
                        end else begin
                            d_reg <= divisor;
                            q_reg <= dividendo;
                            r_reg <= '0;
                            cnt   <= '0;
                        end
                    end
                end
                ST_CALC: begin
                    q_reg <= q_nxt;
                    r_reg <= r_nxt;
                    cnt   <= cnt + 1'b1;
                    // Published results change only on the final iteration.
                    if (cnt == CNT_LAST) begin
                        quociente <= q_nxt;
                        resto     <= r_nxt;
                        div_zero  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_sequencial.sv
// Scoreboard bench for divisor_sequencial: directed operations plus a back-to-back sweep.
`timescale 1ns/1ps
module tb_divisor_sequencial;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividendo, divisor;
    logic [7:0] quociente, resto;
    logic       busy, done, div_zero;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   accepted = 0;

    divisor_sequencial #(.N_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividendo (dividendo),
        .divisor   (divisor),
        .quociente (quociente),
        .resto     (resto),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expected result per done pulse.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("busy_and_done_exclusive", int'(busy & done), 0);
            if (done === 1'b1) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("quociente", int'(quociente), int'(e.q));
                    check("resto", int'(resto), int'(e.r));
                    check("div_zero", int'(div_zero), int'(e.dz));
                end
            end
        end
    end

    task automatic wait_idle(input string tag);
        int w;
        w = 0;
        while ((busy || done) && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 40) check({tag, "_idle_timeout"}, 1, 0);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic edz,
                          input int elat, input string tag);
        int lat, nbusy;
        wait_idle(tag);
        sb.push_back('{q: eq, r: er, dz: edz});
        accepted++;
        dividendo = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        nbusy = 0;
        while (!done && lat < 30) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, elat);
        check({tag, "_busy_cycles"}, nbusy, elat - 1);
    endtask

    initial begin
        int lat;
        rst       = 1'b1;
        start     = 1'b0;
        dividendo = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_quociente", int'(quociente), 0);
        check("reset_resto", int'(resto), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_div_zero", int'(div_zero), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 9, "op_200_7");
        run_op(8'd255, 8'd128, 8'd1,   8'd127, 1'b0, 9, "op_255_128");
        run_op(8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9, "op_255_1");
        run_op(8'd0,   8'd9,   8'd0,   8'd0,   1'b0, 9, "op_0_9");
        run_op(8'd5,   8'd0,   8'hFF,  8'd5,   1'b1, 1, "op_5_div0");
        run_op(8'd9,   8'd3,   8'd3,   8'd0,   1'b0, 9, "op_9_3");

        // 100/9 with a second start during CALC that must be ignored.
        wait_idle("hold");
        sb.push_back('{q: 8'd11, r: 8'd1, dz: 1'b0});
        accepted++;
        dividendo = 8'd100;
        divisor   = 8'd9;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("hold_prev_quociente", int'(quociente), 3);
        check("hold_prev_resto", int'(resto), 0);
        lat = 1;
        repeat (3) begin @(posedge clk); #1; lat++; end
        dividendo = 8'd50;
        divisor   = 8'd5;
        start     = 1'b1;
        @(posedge clk); #1;
        lat++;
        start = 1'b0;
        check("hold_mid_quociente", int'(quociente), 3);
        while (!done && lat < 30) begin @(posedge clk); #1; lat++; end
        check("hold_latency", lat, 9);
        repeat (12) begin
            @(posedge clk); #1;
            check("hold_no_second_op", int'(busy | done), 0);
        end

        // Asynchronous reset in the middle of 200/7.
        dividendo = 8'd200;
        divisor   = 8'd7;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        check("arst_quociente", int'(quociente), 0);
        check("arst_resto", int'(resto), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_div_zero", int'(div_zero), 0);
        #1 rst = 1'b0;
        run_op(8'd17, 8'd4, 8'd4, 8'd1, 1'b0, 9, "op_17_4_after_rst");

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            run_op(a, b, a / b, a % b, 1'b0, 9, "sweep");
        end

        repeat (5) @(posedge clk);
        #1;
        check("done_count", done_cnt, accepted);
        check("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish before 1000000ns");
        $fatal(1, "timeout");
    end

endmodule
